// File: rtl/sprite_rom_arbiter.sv
// Purpose: two-requester arbiter sharing one 130x31 4-bit sprite ROM, with (x,y) to address mapping and out-of-bounds trapping.
// Latency: fixed 2 cycles from acceptance to rspN_valid; responses return in acceptance order, one request per cycle sustained.
// Backpressure: requesters are stalled by reqN_ready (alternating priority, hold blocks grants); responses cannot be stalled.
module sprite_rom_arbiter #(
    parameter int                SPR_W       = 130,
    parameter int                SPR_H       = 31,
    parameter int                ADDR_W      = 12,
    parameter int                DATA_W      = 4,
    parameter logic [DATA_W-1:0] TRANSPARENT = 4'h0
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              hold,
    input  logic              req0_valid,
    input  logic [7:0]        req0_x,
    input  logic [4:0]        req0_y,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [7:0]        req1_x,
    input  logic [4:0]        req1_y,
    output logic              req1_ready,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data,
    output logic              rsp0_oob,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data,
    output logic              rsp1_oob
);

    // 8-bit x and 5-bit y give at most 31*130+255 = 4285, so 13 bits hold the
    // untruncated linear address.
    localparam int         LIN_W   = 13;
    localparam logic [7:0] SPR_W_X = 8'(SPR_W);
    localparam logic [4:0] SPR_H_Y = 5'(SPR_H);

    logic              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              s1_vld_q, s1_vld_d;
    logic              s1_id_q, s1_id_d;
    logic              s1_oob_q, s1_oob_d;
    logic              s2_vld_q, s2_vld_d;
    logic              s2_id_q, s2_id_d;
    logic              s2_oob_q, s2_oob_d;

    logic              gnt0, gnt1;
    logic              accept;
    logic              sel_id;
    logic [7:0]        sel_x;
    logic [4:0]        sel_y;
    logic              sel_oob;
    logic [LIN_W-1:0]  lin_addr;

    // Grant: a lone requester wins; on contention the one not granted last time wins; hold blocks all grants.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!hold) begin
            if (req0_valid && req1_valid) begin
                gnt0 = last_grant_q;
                gnt1 = !last_grant_q;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign accept     = gnt0 | gnt1;

    // Mux the winning coordinate, bounds-check it and form the linear ROM address.
    always_comb begin
        sel_id   = gnt1;
        sel_x    = gnt1 ? req1_x : req0_x;
        sel_y    = gnt1 ? req1_y : req0_y;
        sel_oob  = (sel_x >= SPR_W_X) || (sel_y >= SPR_H_Y);
        lin_addr = LIN_W'(sel_y) * LIN_W'(SPR_W) + LIN_W'(sel_x);
    end

    // Next state: the address register holds when idle, the tag pipe shifts every cycle.
    always_comb begin
        rom_addr_d   = rom_addr_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            rom_addr_d   = sel_oob ? '0 : ADDR_W'(lin_addr);
            last_grant_d = sel_id;
        end
        s1_vld_d = accept;
        s1_id_d  = sel_id;
        s1_oob_d = sel_oob & accept;
        s2_vld_d = s1_vld_q;
        s2_id_d  = s1_id_q;
        s2_oob_d = s1_oob_q;
    end

    // State registers; reset drops any in-flight reads and points priority at requester 0.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            last_grant_q <= 1'b1;
            rom_addr_q   <= '0;
            s1_vld_q     <= 1'b0;
            s1_id_q      <= 1'b0;
            s1_oob_q     <= 1'b0;
            s2_vld_q     <= 1'b0;
            s2_id_q      <= 1'b0;
            s2_oob_q     <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            rom_addr_q   <= rom_addr_d;
            s1_vld_q     <= s1_vld_d;
            s1_id_q      <= s1_id_d;
            s1_oob_q     <= s1_oob_d;
            s2_vld_q     <= s2_vld_d;
            s2_id_q      <= s2_id_d;
            s2_oob_q     <= s2_oob_d;
        end
    end

    assign rom_addr = rom_addr_q;

    // Steer ROM data to the owner of the stage-2 tag; idle ports and trapped reads show TRANSPARENT.
    always_comb begin
        rsp0_valid = s2_vld_q && !s2_id_q;
        rsp1_valid = s2_vld_q && s2_id_q;
        rsp0_oob   = rsp0_valid && s2_oob_q;
        rsp1_oob   = rsp1_valid && s2_oob_q;
        rsp0_data  = (rsp0_valid && !s2_oob_q) ? rom_data : TRANSPARENT;
        rsp1_data  = (rsp1_valid && !s2_oob_q) ? rom_data : TRANSPARENT;
    end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Purpose: scoreboard bench for sprite_rom_arbiter against a behavioural ROM and arbitration model.
// Latency: expects responses exactly 2 cycles after acceptance, rom_addr one cycle after.
// Backpressure: requesters hold coordinates until their ready is seen; responses are consumed immediately.
module tb_sprite_rom_arbiter;

    localparam int         SPR_W  = 130;
    localparam int         SPR_H  = 31;
    localparam logic [3:0] TRANSP = 4'h0;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        hold = 1'b0;
    logic        req0_valid = 1'b0;
    logic [7:0]  req0_x = '0;
    logic [4:0]  req0_y = '0;
    logic        req0_ready;
    logic        req1_valid = 1'b0;
    logic [7:0]  req1_x = '0;
    logic [4:0]  req1_y = '0;
    logic        req1_ready;
    logic [11:0] rom_addr;
    logic [3:0]  rom_data = '0;
    logic        rsp0_valid, rsp0_oob, rsp1_valid, rsp1_oob;
    logic [3:0]  rsp0_data, rsp1_data;

    sprite_rom_arbiter dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .hold       (hold),
        .req0_valid (req0_valid),
        .req0_x     (req0_x),
        .req0_y     (req0_y),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_x     (req1_x),
        .req1_y     (req1_y),
        .req1_ready (req1_ready),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .rsp0_valid (rsp0_valid),
        .rsp0_data  (rsp0_data),
        .rsp0_oob   (rsp0_oob),
        .rsp1_valid (rsp1_valid),
        .rsp1_data  (rsp1_data),
        .rsp1_oob   (rsp1_oob)
    );

    always #5 Clk = ~Clk;

    // Sprite ROM with a registered output.
    logic [3:0] mem [4096];
    always @(posedge Clk) rom_data <= mem[rom_addr];

    typedef struct packed {
        logic [31:0] cyc;
        logic        id;
        logic        oob;
        logic [3:0]  data;
    } exp_t;

    typedef struct packed {
        logic [7:0] x;
        logic [4:0] y;
    } crd_t;

    exp_t sb[$];
    crd_t pend0[$];
    crd_t pend1[$];

    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    bit          lg_m = 1'b1;
    logic [11:0] exp_addr = '0;
    bit          acc0 = 1'b0;
    bit          acc1 = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, req);
        end
    endtask

    always @(posedge Clk) cyc++;

    // Requester drivers: present the head of each pending queue until it is accepted.
    always @(posedge Clk) begin
        #1;
        if (acc0 && pend0.size() > 0) void'(pend0.pop_front());
        if (acc1 && pend1.size() > 0) void'(pend1.pop_front());
        req0_valid = pend0.size() > 0;
        req1_valid = pend1.size() > 0;
        if (pend0.size() > 0) begin req0_x = pend0[0].x; req0_y = pend0[0].y; end
        if (pend1.size() > 0) begin req1_x = pend1[0].x; req1_y = pend1[0].y; end
    end

    // Monitor and reference model, sampled mid-cycle.
    always @(negedge Clk) begin
        exp_t e;
        bit   due, g0, g1, oob;
        int   x, y, lin;
        if (!Reset_n) begin
            chk("rst_rom_addr", rom_addr, 0);
            chk("rst_rsp0_valid", rsp0_valid, 0);
            chk("rst_rsp1_valid", rsp1_valid, 0);
            chk("rst_rsp0_oob", rsp0_oob, 0);
            chk("rst_rsp1_oob", rsp1_oob, 0);
            chk("rst_rsp0_data", rsp0_data, TRANSP);
            chk("rst_rsp1_data", rsp1_data, TRANSP);
            sb.delete();
            lg_m     = 1'b1;
            exp_addr = '0;
            acc0     = 1'b0;
            acc1     = 1'b0;
        end else begin
            chk("rom_addr", rom_addr, exp_addr);
            due = (sb.size() > 0) && (sb[0].cyc + 2 == cyc);
            e   = due ? sb[0] : '0;
            chk("rsp0_valid", rsp0_valid, due && !e.id);
            chk("rsp1_valid", rsp1_valid, due && e.id);
            if (due && !e.id) begin
                chk("rsp0_data", rsp0_data, e.data);
                chk("rsp0_oob", rsp0_oob, e.oob);
                chk("idle_rsp1_data", rsp1_data, TRANSP);
                chk("idle_rsp1_oob", rsp1_oob, 0);
            end else if (due) begin
                chk("rsp1_data", rsp1_data, e.data);
                chk("rsp1_oob", rsp1_oob, e.oob);
                chk("idle_rsp0_data", rsp0_data, TRANSP);
                chk("idle_rsp0_oob", rsp0_oob, 0);
            end else begin
                chk("idle_rsp0_data", rsp0_data, TRANSP);
                chk("idle_rsp1_data", rsp1_data, TRANSP);
                chk("idle_rsp0_oob", rsp0_oob, 0);
                chk("idle_rsp1_oob", rsp1_oob, 0);
            end
            if (due) void'(sb.pop_front());

            // Alternating-priority arbitration, hold blocks everything.
            g0 = !hold && req0_valid && (!req1_valid || lg_m);
            g1 = !hold && req1_valid && (!req0_valid || !lg_m);
            chk("req0_ready", req0_ready, g0);
            chk("req1_ready", req1_ready, g1);
            acc0 = g0;
            acc1 = g1;
            if (g0 || g1) begin
                x   = g1 ? int'(req1_x) : int'(req0_x);
                y   = g1 ? int'(req1_y) : int'(req0_y);
                oob = (x >= SPR_W) || (y >= SPR_H);
                lin = oob ? 0 : y * SPR_W + x;
                e.cyc  = cyc;
                e.id   = g1;
                e.oob  = oob;
                e.data = oob ? TRANSP : mem[lin];
                sb.push_back(e);
                exp_addr = 12'(lin);
                lg_m     = g1;
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #2;
    endtask

    task automatic push(input bit id, input int x, input int y);
        crd_t c;
        c.x = 8'(x);
        c.y = 5'(y);
        if (id) pend1.push_back(c);
        else    pend0.push_back(c);
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        pend0.delete();
        pend1.delete();
        step();
        step();
        Reset_n = 1'b1;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((pend0.size() > 0 || pend1.size() > 0 || sb.size() > 0) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout cycle=%0d pend0=%0d pend1=%0d sb=%0d", cyc, pend0.size(), pend1.size(), sb.size());
        end
        step();
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 4'($urandom_range(1, 15));
        mem[0] = 4'hA;
        repeat (3) @(posedge Clk);
        #2;
        Reset_n = 1'b1;

        // Single read
        push(0, 5, 2);
        wait_drain(20);

        // Corner coordinates back to back
        push(0, 0, 0);
        push(0, 129, 0);
        push(0, 0, 30);
        push(0, 129, 30);
        wait_drain(20);

        // Out-of-bounds on requester 1
        push(1, 130, 0);
        push(1, 0, 31);
        wait_drain(20);

        // Contention straight after reset
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push(0, i * 7, i);
            push(1, 100 + i, 20 + i);
        end
        wait_drain(30);

        // Hold with a read in flight
        push(0, 10, 10);
        push(0, 11, 11);
        push(1, 12, 12);
        push(1, 13, 13);
        step();
        step();
        hold = 1'b1;
        repeat (3) step();
        hold = 1'b0;
        wait_drain(30);

        // Reset one cycle after an acceptance
        push(0, 40, 5);
        step();
        step();
        Reset_n = 1'b0;
        step();
        Reset_n = 1'b1;
        wait_drain(20);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            step();
            for (int r = 0; r < 2; r++) begin
                int sz = (r == 0) ? pend0.size() : pend1.size();
                if (sz < 3 && ($urandom % 2) == 0) begin
                    int x = ($urandom % 16 == 0) ? int'($urandom_range(130, 255)) : int'($urandom_range(0, 129));
                    int y = int'($urandom_range(0, 31));
                    push(r[0], x, y);
                end
            end
            hold = ($urandom % 8) == 0;
            if ($urandom % 400 == 0) begin
                hold = 1'b0;
                do_reset();
            end
        end
        hold = 1'b0;
        wait_drain(100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sprite_rom_arbiter.md
# sprite_rom_arbiter

Shares one 130x31 4-bit sprite ROM between two pixel requesters, such as the start-screen renderer and the overlay renderer. It converts each request's (x, y) sprite coordinate into a linear ROM address and drives the ROM's read address. It then returns the ROM's registered output to the requester that issued the read, tagged with a valid strobe. Out-of-bounds coordinates are trapped and answered with a transparent pixel. The block sits between the ROM and the color-mapping/drawing logic.

## Interface
- SPR_W, 130, sprite width in pixels
- SPR_H, 31, sprite height in pixels
- ADDR_W, 12, ROM address width
- DATA_W, 4, ROM data width (palette index)
- TRANSPARENT, 4'h0, palette index returned for out-of-bounds requests
- Clk  in  1  single clock; all state is updated on the rising edge
- Reset_n  in  1  reset, asynchronous, active-low
- hold  in  1  when high, no new request is granted; in-flight reads still complete
- req0_valid  in  1  requester 0 has a coordinate to read
- req0_x  in  8  requester 0 column
- req0_y  in  5  requester 0 row
- req0_ready  out  1  requester 0 is granted this cycle
- req1_valid, req1_x, req1_y, req1_ready  same as requester 0, for requester 1
- rom_addr  out  ADDR_W  registered read address driven to the ROM
- rom_data  in  DATA_W  ROM output, registered inside the ROM one edge after rom_addr
- rsp0_valid  out  1  response for requester 0 is present this cycle
- rsp0_data  out  DATA_W  pixel index for requester 0
- rsp0_oob  out  1  the returned pixel was forced to TRANSPARENT
- rsp1_valid, rsp1_data, rsp1_oob  same as requester 0, for requester 1

## Operation
- Handshake: a request is accepted in a cycle where reqN_valid and reqN_ready are both high. Requesters hold x, y and valid stable until accepted.
- Arbitration:
  - reqN_ready is combinational from the valids, hold and the priority pointer.
  - At most one ready is high per cycle, and none while hold=1.
  - If only one requester is valid, that requester is granted.
  - If both are valid, the requester other than last_grant is granted.
  - last_grant updates only on acceptance.
- Bounds check on the accepted request: oob = (x >= SPR_W) or (y >= SPR_H).
- Address: addr = y*SPR_W + x, computed at full width and truncated to ADDR_W. The maximum legal value is 30*130+129 = 4029. When oob=1, the address is forced to 0.
- Pipeline, two stages of tag registers:
  - S1 holds {valid, id, oob} for the request whose address is currently on rom_addr.
  - S2 holds the same tag for the request whose data is currently on rom_data.
- Response:
  - rspN_valid = S2.valid and (S2.id == N).
  - rspN_data = TRANSPARENT when S2.oob=1, otherwise rom_data.
  - rspN_oob = S2.oob and rspN_valid.
  - When rspN_valid=0, rspN_data equals TRANSPARENT.
- Responses have no backpressure; consumers must take them in the cycle they are presented.
- Throughput is one accepted request per cycle, sustained, across both requesters.

## Timing
- A request accepted in cycle n:
  - puts rom_addr valid in cycle n+1;
  - puts rom_data valid in cycle n+2;
  - asserts rspN_valid in cycle n+2.
- Fixed latency is 2 cycles. Responses are returned in acceptance order.
- When no request is accepted, rom_addr holds its previous value and S1.valid becomes 0.
- hold takes effect combinationally in the same cycle. Requests already in S1 or S2 still respond on schedule.
- Reset (Reset_n=0) at any time takes effect immediately:
  - rom_addr = 0; S1 and S2 cleared; all rspN_valid = 0; all rspN_oob = 0; all rspN_data = TRANSPARENT.
  - last_grant = 1, so requester 0 wins the first contended cycle.
  - In-flight reads are discarded and never answered.
- Release of Reset_n is synchronous to Clk at the system level. The first acceptance can occur in the first cycle after release.

## Test plan
- Single read: after reset, req0 (x=5, y=2) held one cycle. Required: req0_ready=1 in that cycle; rom_addr=265 in the next cycle; rsp0_valid=1 two cycles after acceptance, with rsp0_data = mem[265] and rsp0_oob=0. rsp1_valid stays 0.
- Corners: back-to-back requests (0,0), (129,0), (0,30), (129,30). Required: rom_addr = 0, 129, 3900, 4029 on consecutive cycles, and four consecutive rsp0_valid pulses with matching data.
- Out-of-bounds: req1 (x=130, y=0), then (x=0, y=31). Required: rom_addr=0 for both, rsp1_valid=1, rsp1_oob=1 and rsp1_data=TRANSPARENT for both, regardless of mem[0].
- Contention: both requesters valid continuously for 6 cycles after reset. Required: grants alternate 0,1,0,1,0,1, and responses alternate rsp0/rsp1 two cycles later with no gaps.
- Hold: hold=1 for 3 cycles with both valid, one request already in flight. Required: no ready asserted; the in-flight response still arrives on schedule; granting resumes the cycle hold drops, with the pointer unchanged.
- Reset mid-flight: assert Reset_n=0 one cycle after an acceptance. Required: rom_addr=0 and all rspN_valid=0 immediately; no response is ever produced for the discarded request.
